// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 for the 5-stage MIPS core: SR/Cause/EPC storage, exception/interrupt
// decision at the M stage, and the combinational Req flush request for the pipeline.
module cp0_exc_ctrl #(
    parameter logic [4:0]  EXCNO   = 5'h1f,
    parameter logic [4:0]  EXC_INT = 5'd0,
    parameter logic [31:0] PRID    = 32'h2024_0001
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [4:0]  CP0Add_i,
    input  logic [31:0] CP0In_i,
    output logic [31:0] CP0Out_o,
    input  logic [31:0] VPC_i,
    input  logic        BDIn_i,
    input  logic [4:0]  ExcCodeIn_i,
    input  logic [5:0]  HWInt_i,
    input  logic        EXLClr_i,
    output logic        Req_o,
    output logic [31:0] EPCOut_o
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // Only the architecturally defined fields are stored; every other bit reads as zero.
    logic [5:0]  imQ, imD;
    logic        exlQ, exlD;
    logic        ieQ, ieD;
    logic        bdQ, bdD;
    logic [5:0]  ipQ, ipD;
    logic [4:0]  excCodeQ, excCodeD;
    logic [31:0] epcQ, epcD;

    logic        intReq;
    logic        excReq;
    logic        reqInt;
    logic        srWrite;
    logic        epcWrite;
    logic [31:0] srValue;
    logic [31:0] causeValue;

    assign intReq = ~exlQ & ieQ & (|(HWInt_i & imQ));
    assign excReq = ~exlQ & (ExcCodeIn_i != EXCNO);
    assign reqInt = ~reset_i & (intReq | excReq);
    assign Req_o  = reqInt;

    assign srWrite  = en_i & ~reqInt & (CP0Add_i == ADDR_SR);
    assign epcWrite = en_i & ~reqInt & (CP0Add_i == ADDR_EPC);

    assign srValue    = {16'd0, imQ, 8'd0, exlQ, ieQ};
    assign causeValue = {bdQ, 15'd0, ipQ, 3'd0, excCodeQ, 2'b00};
    assign EPCOut_o   = epcQ;

    always_comb begin
        imD      = imQ;
        exlD     = exlQ;
        ieD      = ieQ;
        bdD      = bdQ;
        ipD      = HWInt_i;
        excCodeD = excCodeQ;
        epcD     = epcQ;

        if (reqInt) begin
            exlD     = 1'b1;
            bdD      = BDIn_i;
            excCodeD = intReq ? EXC_INT : ExcCodeIn_i;
            epcD     = BDIn_i ? (VPC_i - 32'd4) : VPC_i;
        end else begin
            if (srWrite) begin
                imD  = CP0In_i[15:10];
                exlD = CP0In_i[1];
                ieD  = CP0In_i[0];
            end
            if (epcWrite) begin
                epcD = CP0In_i;
            end
            // eret overrides an mtc0 to SR issued in the same cycle
            if (EXLClr_i) begin
                exlD = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            imQ      <= '0;
            exlQ     <= 1'b0;
            ieQ      <= 1'b0;
            bdQ      <= 1'b0;
            ipQ      <= '0;
            excCodeQ <= '0;
            epcQ     <= '0;
        end else begin
            imQ      <= imD;
            exlQ     <= exlD;
            ieQ      <= ieD;
            bdQ      <= bdD;
            ipQ      <= ipD;
            excCodeQ <= excCodeD;
            epcQ     <= epcD;
        end
    end

    always_comb begin
        CP0Out_o = 32'd0;
        case (CP0Add_i)
            ADDR_SR:    CP0Out_o = srValue;
            ADDR_CAUSE: CP0Out_o = causeValue;
            ADDR_EPC:   CP0Out_o = epcQ;
            ADDR_PRID:  CP0Out_o = PRID;
            default:    CP0Out_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: a whole-register model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cp0_exc_ctrl;

    localparam logic [4:0]  EXCNO = 5'h1f;
    localparam logic [31:0] PRID  = 32'h2024_0001;

    logic        clk = 1'b0;
    logic        resetIn;
    logic        enIn;
    logic [4:0]  cp0Add;
    logic [31:0] cp0In;
    logic [31:0] cp0Out;
    logic [31:0] vpc;
    logic        bdIn;
    logic [4:0]  excCodeIn;
    logic [5:0]  hwInt;
    logic        exlClr;
    logic        req;
    logic [31:0] epcOut;

    int checks = 0;
    int errors = 0;
    bit modelValid = 1'b0;

    // Model state held as full 32-bit register images
    logic [31:0] mSr, mCause, mEpc;
    logic [31:0] nSr, nCause, nEpc;
    logic        takeIt;
    logic [4:0]  codeIt;

    cp0_exc_ctrl dut (
        .clk_i       (clk),
        .reset_i     (resetIn),
        .en_i        (enIn),
        .CP0Add_i    (cp0Add),
        .CP0In_i     (cp0In),
        .CP0Out_o    (cp0Out),
        .VPC_i       (vpc),
        .BDIn_i      (bdIn),
        .ExcCodeIn_i (excCodeIn),
        .HWInt_i     (hwInt),
        .EXLClr_i    (exlClr),
        .Req_o       (req),
        .EPCOut_o    (epcOut)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic modelIntReq();
        return !mSr[1] && mSr[0] && ((hwInt & mSr[15:10]) != 6'd0);
    endfunction

    function automatic logic modelReq();
        if (resetIn) return 1'b0;
        return modelIntReq() || (!mSr[1] && (excCodeIn != EXCNO));
    endfunction

    function automatic logic [31:0] modelRead();
        case (cp0Add)
            5'd12:   return mSr;
            5'd13:   return mCause;
            5'd14:   return mEpc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (resetIn) begin
            mSr = 32'd0;
            mCause = 32'd0;
            mEpc = 32'd0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            takeIt = modelReq();
            codeIt = modelIntReq() ? 5'd0 : excCodeIn;
            nSr = mSr;
            nEpc = mEpc;
            nCause = (mCause & ~32'h0000_FC00) | ({26'd0, hwInt} << 10);
            if (takeIt) begin
                nSr = nSr | 32'h2;
                nCause = (nCause & 32'h0000_FC00) | {bdIn, 31'd0} | {25'd0, codeIt, 2'b00};
                nEpc = bdIn ? vpc - 32'd4 : vpc;
            end else begin
                if (enIn && cp0Add == 5'd12) nSr = cp0In & 32'h0000_FC03;
                if (enIn && cp0Add == 5'd14) nEpc = cp0In;
                if (exlClr) nSr = nSr & ~32'h2;
            end
            mSr = nSr;
            mCause = nCause;
            mEpc = nEpc;
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model_req", {31'd0, req}, {31'd0, modelReq()});
            checkOutput("model_epcout", epcOut, mEpc);
            checkOutput("model_cp0out", cp0Out, modelRead());
        end
    end

    task automatic applyStimulus(input logic rst, input logic en, input logic [4:0] add,
                                 input logic [31:0] din, input logic [31:0] pc, input logic bd,
                                 input logic [4:0] code, input logic [5:0] hw, input logic clr);
        @(posedge clk);
        #1;
        resetIn = rst;
        enIn = en;
        cp0Add = add;
        cp0In = din;
        vpc = pc;
        bdIn = bd;
        excCodeIn = code;
        hwInt = hw;
        exlClr = clr;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [5:0] hw);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3000, 1'b0, EXCNO, hw, 1'b0);
    endtask

    task automatic eret();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3000, 1'b0, EXCNO, 6'd0, 1'b1);
    endtask

    task automatic readReg(input string name, input logic [4:0] add, input logic [31:0] expected);
        cp0Add = add;
        #1;
        checkOutput(name, cp0Out, expected);
    endtask

    initial begin
        resetIn = 1'b1; enIn = 1'b0; cp0Add = 5'd0; cp0In = 32'd0; vpc = 32'd0;
        bdIn = 1'b0; excCodeIn = EXCNO; hwInt = 6'd0; exlClr = 1'b0;

        $display("[TB] reset with a pending exception code");
        applyStimulus(1'b1, 1'b0, 5'd12, 32'd0, 32'h0000_3000, 1'b0, 5'd4, 6'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd12, 32'd0, 32'h0000_3000, 1'b0, 5'd4, 6'd0, 1'b0);
        checkOutput("reset_req", {31'd0, req}, 32'd0);
        idle(6'd0);
        readReg("reset_sr", 5'd12, 32'd0);
        readReg("reset_cause", 5'd13, 32'd0);
        readReg("reset_epc", 5'd14, 32'd0);
        checkOutput("reset_epcout", epcOut, 32'd0);

        $display("[TB] interrupt");
        applyStimulus(1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'h0000_3004, 1'b0, EXCNO, 6'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3008, 1'b0, EXCNO, 6'b000001, 1'b0);
        checkOutput("int_req", {31'd0, req}, 32'd1);
        idle(6'b000001);
        checkOutput("int_req_after", {31'd0, req}, 32'd0);
        readReg("int_sr", 5'd12, 32'h0000_0403);
        readReg("int_cause", 5'd13, 32'h0000_0400);
        readReg("int_epc", 5'd14, 32'h0000_3008);

        $display("[TB] masking while EXL is set");
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3040, 1'b0, 5'd4, 6'h3f, 1'b0);
        checkOutput("mask_req", {31'd0, req}, 32'd0);
        eret();
        checkOutput("mask_epc", epcOut, 32'h0000_3008);
        applyStimulus(1'b0, 1'b0, 5'd12, 32'd0, 32'h0000_3020, 1'b1, 5'd12, 6'b000001, 1'b0);
        checkOutput("eret_pending_req", {31'd0, req}, 32'd1);
        readReg("eret_sr", 5'd12, 32'h0000_0401);
        idle(6'd0);
        readReg("prio_cause", 5'd13, 32'h8000_0400);
        readReg("prio_epc", 5'd14, 32'h0000_301C);

        $display("[TB] delay-slot exception");
        applyStimulus(1'b0, 1'b1, 5'd12, 32'd0, 32'h0000_3000, 1'b0, EXCNO, 6'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3010, 1'b1, 5'd12, 6'd0, 1'b0);
        checkOutput("ds_req", {31'd0, req}, 32'd1);
        idle(6'd0);
        readReg("ds_epc", 5'd14, 32'h0000_300C);
        readReg("ds_cause", 5'd13, 32'h8000_0030);
        readReg("ds_sr", 5'd12, 32'h0000_0002);

        $display("[TB] mtc0 EPC conflicting with an exception");
        eret();
        applyStimulus(1'b0, 1'b1, 5'd14, 32'hDEAD_BEEF, 32'h0000_3000, 1'b0, 5'd10, 6'd0, 1'b0);
        checkOutput("conf_req", {31'd0, req}, 32'd1);
        idle(6'd0);
        readReg("conf_epc", 5'd14, 32'h0000_3000);
        readReg("conf_cause", 5'd13, 32'h0000_0028);

        $display("[TB] exception coinciding with eret");
        eret();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_4000, 1'b0, 5'd8, 6'd0, 1'b1);
        checkOutput("req_eret_req", {31'd0, req}, 32'd1);
        idle(6'd0);
        readReg("req_eret_sr", 5'd12, 32'h0000_0002);
        checkOutput("req_eret_epcout", epcOut, 32'h0000_4000);

        $display("[TB] read map");
        eret();
        applyStimulus(1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0000_3000, 1'b0, EXCNO, 6'd0, 1'b0);
        checkOutput("sr_write_req", {31'd0, req}, 32'd0);
        idle(6'd0);
        readReg("sr_mask", 5'd12, 32'h0000_FC03);
        readReg("prid", 5'd15, 32'h2024_0001);
        readReg("unmapped", 5'd7, 32'd0);

        $display("[TB] EPC wrap in a delay slot");
        eret();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_0002, 1'b1, 5'd5, 6'd0, 1'b0);
        checkOutput("wrap_req", {31'd0, req}, 32'd1);
        idle(6'd0);
        readReg("wrap_epc", 5'd14, 32'hFFFF_FFFE);
        readReg("wrap_cause", 5'd13, 32'h8000_0014);

        $display("[TB] reset mid-handler and read-only Cause");
        applyStimulus(1'b1, 1'b0, 5'd12, 32'd0, 32'h0000_3000, 1'b0, 5'd4, 6'd0, 1'b0);
        checkOutput("midreset_req", {31'd0, req}, 32'd0);
        idle(6'd0);
        readReg("midreset_sr", 5'd12, 32'd0);
        checkOutput("midreset_epcout", epcOut, 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0000_3000, 1'b0, EXCNO, 6'd0, 1'b0);
        idle(6'd0);
        readReg("cause_ro", 5'd13, 32'd0);

        idle(6'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
